sim_run_ctrl: RTL and testbench
===============================

// Module: sim_run_ctrl
// PURPOSE
//  Parametrised run controller between the simulation top and riscv_top-style cores.
//  Replaces free-running clock/reset-only stimulus with four functions:
//   - counted reset hold before the core runs;
//   - optional periodic ready throttling, to stress stall paths;
//   - detection of the halt I/O write and the character-output I/O write;
//   - a cycle-limit watchdog that freezes the core and flags TIMEOUT.
//  Synthesisable; the bench watches done_out/timeout_out to end the run.
// PARAMETERS
//  ADDR_W      18        I/O address width
//  CNT_W       32        cycle counter width
//  RST_CYCLES  25        cycles core_rst_out is held high after reset release (>=1)
//  MAX_CYCLES  0         watchdog limit on active cycles; 0 = watchdog disabled
//  RDY_PERIOD  0         core_rdy_out is low 1 cycle in every RDY_PERIOD; 0 = always ready
//  HALT_ADDR   'h30004   write here = program end
//  CHAR_ADDR   'h30000   write here = emit io_data_in[7:0] as a character
// PORTS
//  clk_in          in   1       system clock, single domain
//  rst_n_in        in   1       asynchronous, active-low reset
//  core_rst_out    out  1       active-high reset to the core
//  core_rdy_out    out  1       ready/enable to the core
//  io_wr_in        in   1       core I/O write strobe
//  io_addr_in      in   ADDR_W  core I/O address
//  io_data_in      in   8       core I/O write data
//  char_valid_out  out  1       1-cycle pulse: char_out valid
//  char_out        out  8       captured character
//  cycle_cnt_out   out  CNT_W   active (ready) cycles since RUN entry
//  done_out        out  1       sticky: halt write seen
//  timeout_out     out  1       sticky: watchdog expired
//  state_out       out  2       0 HOLD, 1 RUN, 2 DONE, 3 TIMEOUT
// BEHAVIOUR
//  Reset (async assert, any time, including mid-run)
//   - state HOLD; core_rst_out=1, core_rdy_out=0.
//   - char_valid_out=0, char_out=0, cycle_cnt_out=0, done_out=0, timeout_out=0.
//   - hold and phase counters = 0.
//   - All outputs are registered.
//  HOLD
//   - Hold counter increments every cycle.
//   - When it equals RST_CYCLES-1: enter RUN next edge; core_rst_out=0 and core_rdy_out
//     take their RUN values from that same edge.
//  RUN, ready pattern
//   - RDY_PERIOD=0: core_rdy_out=1 every cycle.
//   - Otherwise a phase counter runs 0..RDY_PERIOD-1 and wraps to 0;
//     core_rdy_out=0 only in phase RDY_PERIOD-1.
//  RUN, cycle count
//   - cycle_cnt_out increments on each cycle with core_rdy_out=1.
//   - Saturates at all-ones; never wraps.
//  RUN, I/O writes
//   - Sampled only when io_wr_in=1 AND core_rdy_out=1.
//   - addr==CHAR_ADDR: char_out<=io_data_in; char_valid_out=1 for exactly one cycle,
//     latency 1. Back-to-back writes give back-to-back pulses.
//   - addr==HALT_ADDR: enter DONE next edge; done_out=1.
//   - Any other address: ignored.
//  Watchdog (MAX_CYCLES!=0)
//   - Counted cycle_cnt_out value reaching MAX_CYCLES enters TIMEOUT; timeout_out=1.
//  Simultaneous events
//   - Halt write in the same cycle as watchdog expiry: DONE wins, timeout_out stays 0.
//  DONE / TIMEOUT
//   - Terminal until reset; core_rdy_out=0 (core frozen), core_rst_out=0.
//   - cycle_cnt_out frozen; char_valid_out=0; further I/O writes ignored.
// STRUCTURE
//  Shared package (sim_pkg)
//   - state encoding localparams ST_HOLD/ST_RUN/ST_DONE/ST_TIMEOUT.
//   - default HALT_ADDR/CHAR_ADDR constants, shared with the memory/I/O decode.
//  Sub-module sim_rdy_gen
//   - phase counter + ready pattern; ports clk_in, rst_n_in, en, rdy.
//  Remainder: one FSM + counters in this module.
// TESTING
//  1 RST_CYCLES=25: release rst_n_in at t0
//    -> core_rst_out falls exactly 25 edges later; state_out=1.
//  2 Write 'h41 to 'h30000, then 'h42 next cycle
//    -> two consecutive char_valid_out pulses, char_out 'h41 then 'h42.
//  3 Halt write at cycle_cnt 100
//    -> done_out=1, core_rdy_out=0 next cycle; cycle_cnt_out stays 101.
//  4 MAX_CYCLES=50, no halt
//    -> timeout_out=1 after 50 active cycles; halt issued in the expiry cycle gives done_out=1 instead.
//  5 RDY_PERIOD=4 -> rdy pattern 1,1,1,0 repeating; a write while rdy=0 is ignored;
//    cycle_cnt_out advances 3 per 4 cycles.
//  6 Drop rst_n_in mid-RUN
//    -> all outputs return to reset values without waiting for a clock edge; HOLD restarts.

Source files
------------

// File: rtl/sim_pkg.sv
// sim_pkg: shared constants for the simulation run controller and the I/O decode.
// Holds the state encoding seen on state_out and the default I/O addresses
// for the halt and character-output writes.
package sim_pkg;

  // Encoding visible on sim_run_ctrl.state_out
  localparam logic [1:0] ST_HOLD    = 2'd0;
  localparam logic [1:0] ST_RUN     = 2'd1;
  localparam logic [1:0] ST_DONE    = 2'd2;
  localparam logic [1:0] ST_TIMEOUT = 2'd3;

  typedef enum logic [1:0] {
    S_HOLD    = ST_HOLD,
    S_RUN     = ST_RUN,
    S_DONE    = ST_DONE,
    S_TIMEOUT = ST_TIMEOUT
  } run_state_e;

  // Default I/O map, also used by the memory/I/O decode
  localparam int unsigned HALT_ADDR_DEF = 32'h0003_0004;
  localparam int unsigned CHAR_ADDR_DEF = 32'h0003_0000;

endpackage

// File: rtl/sim_rdy_gen.sv
// sim_rdy_gen: periodic ready pattern for the core.
// Ports: clk_in/rst_n_in (clock, async active-low reset), en (the coming cycle
// is a RUN cycle), rdy (registered ready for that cycle).
// PERIOD=0 keeps rdy high whenever enabled; otherwise rdy drops in the last
// phase of every PERIOD-cycle window.
module sim_rdy_gen #(
  parameter int unsigned PERIOD = 0
) (
  input  logic clk_in,
  input  logic rst_n_in,
  input  logic en,
  output logic rdy
);

  localparam int unsigned     PH_W = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam logic [PH_W-1:0] LAST = (PERIOD > 0) ? PH_W'(PERIOD - 1) : '0;

  // phase holds the position of the upcoming RUN cycle inside the window, so
  // the registered rdy already carries the right value on the first RUN cycle.
  logic [PH_W-1:0] phase;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      phase <= '0;
      rdy   <= 1'b0;
    end else if (en) begin
      if (PERIOD == 0) begin
        rdy <= 1'b1;
      end else begin
        rdy   <= (phase != LAST);
        phase <= (phase == LAST) ? '0 : phase + PH_W'(1);
      end
    end else begin
      rdy <= 1'b0;
    end
  end

endmodule

// File: rtl/sim_run_ctrl.sv
// sim_run_ctrl: run controller between the simulation top and a core.
// Ports: clk_in, rst_n_in (async active-low); core_rst_out/core_rdy_out drive
// the core; io_wr_in/io_addr_in/io_data_in observe core I/O writes;
// char_valid_out/char_out report character writes; cycle_cnt_out counts
// ready cycles in RUN; done_out/timeout_out are sticky end flags; state_out
// shows HOLD/RUN/DONE/TIMEOUT. All outputs are registered.
module sim_run_ctrl
  import sim_pkg::*;
#(
  parameter int unsigned       ADDR_W     = 18,
  parameter int unsigned       CNT_W      = 32,
  parameter int unsigned       RST_CYCLES = 25,
  parameter int unsigned       MAX_CYCLES = 0,
  parameter int unsigned       RDY_PERIOD = 0,
  parameter logic [ADDR_W-1:0] HALT_ADDR  = ADDR_W'(HALT_ADDR_DEF),
  parameter logic [ADDR_W-1:0] CHAR_ADDR  = ADDR_W'(CHAR_ADDR_DEF)
) (
  input  logic              clk_in,
  input  logic              rst_n_in,
  output logic              core_rst_out,
  output logic              core_rdy_out,
  input  logic              io_wr_in,
  input  logic [ADDR_W-1:0] io_addr_in,
  input  logic [7:0]        io_data_in,
  output logic              char_valid_out,
  output logic [7:0]        char_out,
  output logic [CNT_W-1:0]  cycle_cnt_out,
  output logic              done_out,
  output logic              timeout_out,
  output logic [1:0]        state_out
);

  localparam int unsigned       HOLD_W    = $clog2(RST_CYCLES + 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RST_CYCLES - 1);

  run_state_e        state_q, state_d;
  logic [HOLD_W-1:0] hold_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [CNT_W-1:0]  cnt_inc;
  logic              active;
  logic              io_acc;
  logic              char_hit;
  logic              halt_hit;
  logic              wd_hit;

  // Ready for the coming cycle depends on whether that cycle is still RUN,
  // so the generator is enabled from the next state.
  sim_rdy_gen #(
    .PERIOD (RDY_PERIOD)
  ) u_rdy_gen (
    .clk_in   (clk_in),
    .rst_n_in (rst_n_in),
    .en       (state_d == S_RUN),
    .rdy      (core_rdy_out)
  );

  always_comb begin
    active   = (state_q == S_RUN) && core_rdy_out;
    cnt_inc  = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);
    io_acc   = active && io_wr_in;
    char_hit = io_acc && (io_addr_in == CHAR_ADDR);
    halt_hit = io_acc && (io_addr_in == HALT_ADDR);
    // Expiry is judged on the count including the current ready cycle.
    wd_hit   = (MAX_CYCLES != 0) && active && (cnt_inc == CNT_W'(MAX_CYCLES));

    state_d = state_q;
    case (state_q)
      S_HOLD: begin
        if (hold_q == HOLD_LAST) state_d = S_RUN;
      end
      S_RUN: begin
        // A halt in the expiry cycle takes precedence over the watchdog.
        if (halt_hit)    state_d = S_DONE;
        else if (wd_hit) state_d = S_TIMEOUT;
      end
      default: state_d = state_q;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q        <= S_HOLD;
      hold_q         <= '0;
      cnt_q          <= '0;
      core_rst_out   <= 1'b1;
      char_valid_out <= 1'b0;
      char_out       <= 8'h00;
      done_out       <= 1'b0;
      timeout_out    <= 1'b0;
    end else begin
      state_q      <= state_d;
      core_rst_out <= (state_d == S_HOLD);
      if (state_q == S_HOLD) hold_q <= hold_q + HOLD_W'(1);
      if (active)            cnt_q  <= cnt_inc;
      // No character pulse once the run has ended, even from the final cycle.
      char_valid_out <= char_hit && (state_d == S_RUN);
      if (char_hit && (state_d == S_RUN)) char_out <= io_data_in;
      if (state_d == S_DONE)    done_out    <= 1'b1;
      if (state_d == S_TIMEOUT) timeout_out <= 1'b1;
    end
  end

  assign cycle_cnt_out = cnt_q;
  assign state_out     = state_q;

endmodule

// File: tb/tb_sim_run_ctrl.sv
// tb_sim_run_ctrl: bench for sim_run_ctrl with three configurations:
// A defaults (hold 25, no watchdog, always ready), B watchdog 50 / hold 4,
// C throttle 4 / hold 3 / 8-bit counter.
module tb_sim_run_ctrl;

  localparam int NI = 3;
  localparam logic [17:0] CHAR_A = 18'h30000;
  localparam logic [17:0] HALT_A = 18'h30004;

  logic clk;
  logic rst_n;
  logic        io_wr   [NI];
  logic [17:0] io_addr [NI];
  logic [7:0]  io_data [NI];

  logic core_rst_a, core_rdy_a, cv_a, done_a, to_a;
  logic core_rst_b, core_rdy_b, cv_b, done_b, to_b;
  logic core_rst_c, core_rdy_c, cv_c, done_c, to_c;
  logic [7:0]  ch_a, ch_b, ch_c;
  logic [31:0] cnt_a, cnt_b;
  logic [7:0]  cnt_c;
  logic [1:0]  st_a, st_b, st_c;

  int total = 0;
  int bad   = 0;

  // Reference model state, per instance
  int     m_st   [NI];
  int     m_hold [NI];
  int     m_k    [NI];
  longint m_cnt  [NI];
  int     m_ch   [NI];
  bit     m_rst  [NI];
  bit     m_rdy  [NI];
  bit     m_cv   [NI];
  bit     m_done [NI];
  bit     m_to   [NI];

  sim_run_ctrl u_a (
    .clk_in(clk), .rst_n_in(rst_n), .core_rst_out(core_rst_a), .core_rdy_out(core_rdy_a),
    .io_wr_in(io_wr[0]), .io_addr_in(io_addr[0]), .io_data_in(io_data[0]),
    .char_valid_out(cv_a), .char_out(ch_a), .cycle_cnt_out(cnt_a),
    .done_out(done_a), .timeout_out(to_a), .state_out(st_a));

  sim_run_ctrl #(.RST_CYCLES(4), .MAX_CYCLES(50)) u_b (
    .clk_in(clk), .rst_n_in(rst_n), .core_rst_out(core_rst_b), .core_rdy_out(core_rdy_b),
    .io_wr_in(io_wr[1]), .io_addr_in(io_addr[1]), .io_data_in(io_data[1]),
    .char_valid_out(cv_b), .char_out(ch_b), .cycle_cnt_out(cnt_b),
    .done_out(done_b), .timeout_out(to_b), .state_out(st_b));

  sim_run_ctrl #(.RST_CYCLES(3), .RDY_PERIOD(4), .CNT_W(8)) u_c (
    .clk_in(clk), .rst_n_in(rst_n), .core_rst_out(core_rst_c), .core_rdy_out(core_rdy_c),
    .io_wr_in(io_wr[2]), .io_addr_in(io_addr[2]), .io_data_in(io_data[2]),
    .char_valid_out(cv_c), .char_out(ch_c), .cycle_cnt_out(cnt_c),
    .done_out(done_c), .timeout_out(to_c), .state_out(st_c));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic int p_rst(int i);
    return (i == 0) ? 25 : (i == 1) ? 4 : 3;
  endfunction
  function automatic longint p_max(int i);
    return (i == 1) ? 50 : 0;
  endfunction
  function automatic int p_per(int i);
    return (i == 2) ? 4 : 0;
  endfunction
  function automatic longint p_lim(int i);
    return (i == 2) ? 255 : 64'h0000_0000_FFFF_FFFF;
  endfunction
  function automatic bit rdy_at(int k, int p);
    return (p == 0) || ((k % p) != p - 1);
  endfunction

  // Observed outputs packed as {rst,rdy,cv,char,cnt,done,timeout,state}
  function automatic logic [46:0] obs(int i);
    logic [46:0] v;
    case (i)
      0:       v = {core_rst_a, core_rdy_a, cv_a, ch_a, cnt_a, done_a, to_a, st_a};
      1:       v = {core_rst_b, core_rdy_b, cv_b, ch_b, cnt_b, done_b, to_b, st_b};
      default: v = {core_rst_c, core_rdy_c, cv_c, ch_c, 24'd0, cnt_c, done_c, to_c, st_c};
    endcase
    return v;
  endfunction

  function automatic logic [46:0] mdl(int i);
    return {m_rst[i], m_rdy[i], m_cv[i], 8'(m_ch[i]), 32'(m_cnt[i]), m_done[i], m_to[i], 2'(m_st[i])};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NI; i++) begin
      m_st[i] = 0; m_hold[i] = 0; m_k[i] = 0; m_cnt[i] = 0; m_ch[i] = 0;
      m_rst[i] = 1'b1; m_rdy[i] = 1'b0; m_cv[i] = 1'b0; m_done[i] = 1'b0; m_to[i] = 1'b0;
    end
  endtask

  // One clock edge of the run rules: m_k is the index of the RUN cycle.
  task automatic model_step(int i);
    bit chr, halt, wd;
    chr = 1'b0; halt = 1'b0; wd = 1'b0;
    m_cv[i] = 1'b0;
    case (m_st[i])
      0: begin
        if (m_hold[i] + 1 == p_rst(i)) begin
          m_st[i] = 1; m_rst[i] = 1'b0; m_k[i] = 0; m_rdy[i] = rdy_at(0, p_per(i));
        end else begin
          m_hold[i]++;
        end
      end
      1: begin
        if (m_rdy[i]) begin
          if (m_cnt[i] < p_lim(i)) m_cnt[i]++;
          chr  = io_wr[i] && (io_addr[i] == CHAR_A);
          halt = io_wr[i] && (io_addr[i] == HALT_A);
          wd   = (p_max(i) != 0) && (m_cnt[i] == p_max(i));
        end
        if (halt) begin
          m_st[i] = 2; m_done[i] = 1'b1; m_rdy[i] = 1'b0;
        end else if (wd) begin
          m_st[i] = 3; m_to[i] = 1'b1; m_rdy[i] = 1'b0;
        end else begin
          if (chr) begin m_cv[i] = 1'b1; m_ch[i] = int'(io_data[i]); end
          m_k[i]++;
          m_rdy[i] = rdy_at(m_k[i], p_per(i));
        end
      end
      default: ;
    endcase
  endtask

  // Advance one clock; returns just after the following falling edge.
  task automatic cycle();
    @(posedge clk);
    if (rst_n) begin
      for (int i = 0; i < NI; i++) model_step(i);
    end else begin
      model_reset();
    end
    @(negedge clk);
  endtask

  task automatic idle_io();
    for (int i = 0; i < NI; i++) begin
      io_wr[i] = 1'b0; io_addr[i] = '0; io_data[i] = '0;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    idle_io();
    cycle();
    cycle();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    logic [46:0] rv;
    rv = {1'b1, 1'b0, 1'b0, 8'h00, 32'h0, 1'b0, 1'b0, 2'd0};
    cycle();
    cycle();
    for (int i = 0; i < NI; i++) begin
      total++;
      if (obs(i) !== rv) begin
        bad++; $display("FAIL reset_values inst=%0d got=%h want=%h", i, obs(i), rv);
      end
      total++;
      if (obs(i) !== mdl(i)) begin
        bad++; $display("FAIL reset_model inst=%0d got=%h want=%h", i, obs(i), mdl(i));
      end
    end
  endtask

  // Count edges from reset release to core_rst falling, for every instance.
  task automatic count_hold(string tag);
    int fall [NI];
    int stf  [NI];
    for (int i = 0; i < NI; i++) begin fall[i] = -1; stf[i] = -1; end
    for (int n = 1; n <= 40; n++) begin
      cycle();
      for (int i = 0; i < NI; i++) begin
        logic [46:0] v;
        v = obs(i);
        if (fall[i] < 0 && v[46] == 1'b0) begin fall[i] = n; stf[i] = int'(v[1:0]); end
        total++;
        if (v !== mdl(i)) begin
          bad++; $display("FAIL %s_model inst=%0d cyc=%0d got=%h want=%h", tag, i, n, v, mdl(i));
        end
      end
    end
    for (int i = 0; i < NI; i++) begin
      total++;
      if (fall[i] !== p_rst(i) || stf[i] !== 1) begin
        bad++;
        $display("FAIL %s_edges inst=%0d got edges=%0d state=%0d want edges=%0d state=1",
                 tag, i, fall[i], stf[i], p_rst(i));
      end
    end
  endtask

  task automatic test_hold();
    rst_n = 1'b1;
    count_hold("hold");
  endtask

  task automatic test_chars();
    io_wr[0] = 1'b1; io_addr[0] = CHAR_A; io_data[0] = 8'h41;
    cycle();
    total++;
    if (cv_a !== 1'b1 || ch_a !== 8'h41) begin
      bad++; $display("FAIL char_first got vld=%b chr=%h want vld=1 chr=41", cv_a, ch_a);
    end
    io_data[0] = 8'h42;
    cycle();
    total++;
    if (cv_a !== 1'b1 || ch_a !== 8'h42) begin
      bad++; $display("FAIL char_second got vld=%b chr=%h want vld=1 chr=42", cv_a, ch_a);
    end
    io_wr[0] = 1'b0;
    cycle();
    total++;
    if (cv_a !== 1'b0 || ch_a !== 8'h42) begin
      bad++; $display("FAIL char_end got vld=%b chr=%h want vld=0 chr=42", cv_a, ch_a);
    end
    // Random traffic, never the halt address
    for (int n = 0; n < 40; n++) begin
      for (int i = 0; i < NI; i++) begin
        int sel;
        sel = int'($urandom_range(0, 3));
        io_wr[i]   = ($urandom_range(0, 2) != 0);
        io_data[i] = 8'($urandom);
        io_addr[i] = (sel < 2) ? CHAR_A : (sel == 2) ? 18'($urandom) : (CHAR_A ^ 18'h1);
        if (io_addr[i] == HALT_A) io_addr[i] = '0;
      end
      cycle();
      for (int i = 0; i < NI; i++) begin
        total++;
        if (obs(i) !== mdl(i)) begin
          bad++; $display("FAIL chars_model inst=%0d n=%0d got=%h want=%h", i, n, obs(i), mdl(i));
        end
      end
    end
    idle_io();
  endtask

  task automatic test_mid_run_reset();
    logic [46:0] rv;
    rv = {1'b1, 1'b0, 1'b0, 8'h00, 32'h0, 1'b0, 1'b0, 2'd0};
    total++;
    if (st_a !== 2'd1) begin
      bad++; $display("FAIL midrst_pre got state=%0d want 1", st_a);
    end
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    for (int i = 0; i < NI; i++) begin
      total++;
      if (obs(i) !== rv) begin
        bad++; $display("FAIL midrst_async inst=%0d got=%h want=%h", i, obs(i), rv);
      end
    end
    @(negedge clk);
    cycle();
    rst_n = 1'b1;
    count_hold("rehold");
  endtask

  task automatic test_halt();
    int guard;
    guard = 0;
    while (cnt_a != 32'd100 && guard < 300) begin
      cycle(); guard++;
    end
    total++;
    if (cnt_a !== 32'd100 || st_a !== 2'd1) begin
      bad++; $display("FAIL halt_reach got cnt=%0d state=%0d want cnt=100 state=1", cnt_a, st_a);
    end
    io_wr[0] = 1'b1; io_addr[0] = HALT_A; io_data[0] = 8'h00;
    cycle();
    io_wr[0] = 1'b0;
    total++;
    if (done_a !== 1'b1 || core_rdy_a !== 1'b0 || cnt_a !== 32'd101 || st_a !== 2'd2 || to_a !== 1'b0) begin
      bad++;
      $display("FAIL halt_done got done=%b rdy=%b cnt=%0d state=%0d to=%b want 1 0 101 2 0",
               done_a, core_rdy_a, cnt_a, st_a, to_a);
    end
    for (int n = 0; n < 6; n++) begin
      io_wr[0] = 1'b1; io_addr[0] = (n[0]) ? CHAR_A : HALT_A; io_data[0] = 8'($urandom);
      cycle();
      total++;
      if (cnt_a !== 32'd101 || cv_a !== 1'b0 || st_a !== 2'd2 || done_a !== 1'b1 || core_rst_a !== 1'b0) begin
        bad++; $display("FAIL halt_frozen n=%0d got cnt=%0d vld=%b state=%0d", n, cnt_a, cv_a, st_a);
      end
      total++;
      if (obs(0) !== mdl(0)) begin
        bad++; $display("FAIL halt_model n=%0d got=%h want=%h", n, obs(0), mdl(0));
      end
    end
    idle_io();
  endtask

  task automatic test_watchdog();
    int n;
    do_reset();
    n = 0;
    while (to_b !== 1'b1 && n < 100) begin
      cycle(); n++;
      total++;
      if (obs(1) !== mdl(1)) begin
        bad++; $display("FAIL wd_model n=%0d got=%h want=%h", n, obs(1), mdl(1));
      end
    end
    total++;
    if (n != 54 || cnt_b !== 32'd50 || st_b !== 2'd3 || done_b !== 1'b0) begin
      bad++; $display("FAIL wd_expire got edges=%0d cnt=%0d state=%0d done=%b want 54 50 3 0",
                      n, cnt_b, st_b, done_b);
    end
    cycle(); cycle();
    total++;
    if (cnt_b !== 32'd50 || core_rdy_b !== 1'b0 || core_rst_b !== 1'b0 || to_b !== 1'b1) begin
      bad++; $display("FAIL wd_frozen got cnt=%0d rdy=%b rst=%b to=%b", cnt_b, core_rdy_b, core_rst_b, to_b);
    end
    // Halt issued in the expiry cycle
    do_reset();
    n = 0;
    while (!(cnt_b == 32'd49 && st_b == 2'd1) && n < 100) begin
      cycle(); n++;
    end
    io_wr[1] = 1'b1; io_addr[1] = HALT_A;
    cycle();
    io_wr[1] = 1'b0;
    total++;
    if (done_b !== 1'b1 || to_b !== 1'b0 || st_b !== 2'd2 || cnt_b !== 32'd50) begin
      bad++; $display("FAIL wd_halt_wins got done=%b to=%b state=%0d cnt=%0d want 1 0 2 50",
                      done_b, to_b, st_b, cnt_b);
    end
    total++;
    if (obs(1) !== mdl(1)) begin
      bad++; $display("FAIL wd_halt_model got=%h want=%h", obs(1), mdl(1));
    end
  endtask

  task automatic test_throttle();
    int n;
    do_reset();
    n = 0;
    while (st_c !== 2'd1 && n < 20) begin
      cycle(); n++;
    end
    for (int k = 0; k < 16; k++) begin
      total++;
      if (core_rdy_c !== rdy_at(k, 4)) begin
        bad++; $display("FAIL thr_pattern k=%0d got=%b want=%b", k, core_rdy_c, rdy_at(k, 4));
      end
      if (k == 4) begin
        total++;
        if (cv_c !== 1'b0) begin
          bad++; $display("FAIL thr_char_ignored got vld=%b want 0", cv_c);
        end
      end
      if (k == 8) begin
        total++;
        if (st_c !== 2'd1 || done_c !== 1'b0) begin
          bad++; $display("FAIL thr_halt_ignored got state=%0d done=%b want 1 0", st_c, done_c);
        end
      end
      io_wr[2]   = (k == 3) || (k == 7);
      io_addr[2] = (k == 3) ? CHAR_A : HALT_A;
      io_data[2] = 8'h5A;
      cycle();
      total++;
      if (obs(2) !== mdl(2)) begin
        bad++; $display("FAIL thr_model k=%0d got=%h want=%h", k, obs(2), mdl(2));
      end
    end
    io_wr[2] = 1'b0;
    total++;
    if (cnt_c !== 8'd12) begin
      bad++; $display("FAIL thr_count got=%0d want 12", cnt_c);
    end
    // Run long enough to saturate the 8-bit counter
    for (int s = 0; s < 400; s++) begin
      cycle();
      total++;
      if (obs(2) !== mdl(2)) begin
        bad++; $display("FAIL sat_model s=%0d got=%h want=%h", s, obs(2), mdl(2));
      end
    end
    total++;
    if (cnt_c !== 8'hFF || st_c !== 2'd1) begin
      bad++; $display("FAIL sat_count got cnt=%0d state=%0d want 255 1", cnt_c, st_c);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    idle_io();
    model_reset();
    @(negedge clk);
    test_reset();
    test_hold();
    test_chars();
    test_mid_run_reset();
    test_halt();
    test_watchdog();
    test_throttle();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
